gpr_wb_arbiter: RTL
===================

// Module: gpr_wb_arbiter
// PURPOSE
//  Shares the single GPR write port (GPRWr/W_Reg/W_data) among NREQ writeback sources, e.g. ALU and load unit.
//  Each source offers a write with a valid/ready handshake. Round-robin picks one source per cycle.
//  The winner is registered on CLK posedge, so the port is stable at the GPR negedge write.
//  Sits between the execute/memory writeback paths and the register file.
// PARAMETERS
//  NREQ     2  number of writeback requesters (2..4)
//  DROP_R0  1  1: accepted writes to register 0 are consumed without asserting GPRWr
// PORTS
//  CLK          in   1        clock, all state changes on posedge
//  RSTn         in   1        asynchronous, active-low reset
//  hold         in   1        1: grant nothing this cycle (pipeline stall)
//  req_valid    in   NREQ     source i offers a write
//  req_reg      in   NREQ*5   dest reg of source i, bits [5i+4:5i]
//  req_data     in   NREQ*32  data of source i, bits [32i+31:32i]
//  req_ready    out  NREQ     one-hot grant; transfer = req_valid[i] & req_ready[i]
//  GPRWr        out  1        write enable to GPR
//  W_Reg        out  5        write address to GPR
//  W_data       out  32       write data to GPR
//  conflict     out  1        registered pulse: more than one source was valid while hold=0
// BEHAVIOUR
//  Reset (RSTn=0, takes effect immediately): GPRWr=0, W_Reg=0, W_data=0, conflict=0, rr_ptr=0.
//   req_ready=0 while RSTn=0. A write registered but not yet taken by GPR is discarded.
//  Grant (combinational):
//   - If hold=1 or no req_valid: req_ready=0.
//   - Else: search indices rr_ptr, rr_ptr+1, ... (mod NREQ). The first valid index g gets req_ready[g]=1.
//   - At most one ready bit is high. req_ready never depends on req_data or req_reg.
//  On posedge with a transfer from g:
//   - W_Reg <= req_reg[g], W_data <= req_data[g].
//   - GPRWr <= 1, except GPRWr <= 0 when DROP_R0=1 and req_reg[g]=0.
//   - rr_ptr <= (g+1) mod NREQ.
//  On posedge with no transfer: GPRWr <= 0. W_Reg, W_data and rr_ptr hold.
//  Latency: exactly 1 cycle from transfer to GPRWr=1. The GPR latches at the following negedge.
//   Throughput is one write per cycle.
//  conflict <= (popcount(req_valid) > 1) & ~hold & RSTn, every posedge.
//  Source handshake rules:
//   - Once req_valid is raised, the source holds req_valid, req_reg and req_data stable until ready.
//   - A source may drop req_valid only after its transfer.
//  Same W_Reg from several sources: writes are serialized in grant order. The last granted value
//   remains in GPR. No merging.
//  Fairness: a continuously valid source is granted within NREQ consecutive non-hold cycles.
//  hold toggling:
//   - hold=1 blocks new grants only. A write registered in the previous cycle still reaches GPR.
//   - rr_ptr is unchanged while hold=1.
//  Width rules: req_reg is 5 bits, so no range check is needed. NREQ outside 2..4 is a synthesis error.
// TESTING
//  1) Reset, then source0 valid only, reg=5, data=32'hDEADBEEF:
//     req_ready=2'b01 at once; next cycle GPRWr=1, W_Reg=5, W_data=32'hDEADBEEF; the cycle after, GPRWr=0.
//  2) Both sources valid for 4 cycles (regs 1 and 2), rr_ptr=0:
//     grants go 0,1,0,1; conflict=1 while both are valid; GPRWr stays high 4 cycles; W_Reg sequence 1,2,1,2.
//  3) Source1 valid with reg=0, data=32'h1234, DROP_R0=1:
//     req_ready[1]=1; next cycle GPRWr=0; rr_ptr advances to 0.
//  4) hold=1 for 3 cycles with both sources valid:
//     req_ready=0 and GPRWr=0 during hold; after hold falls, grant resumes at the saved rr_ptr.
//  5) RSTn pulsed low mid-cycle while GPRWr=1:
//     GPRWr falls before the next CLK edge; after release, grants restart from source0.
//  6) Random valid/hold traffic over 10k cycles, scoreboard against a reference model:
//     no lost or duplicated writes; every source is granted within NREQ non-hold cycles.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter that shares the single GPR write port among NREQ writeback sources.
// The winning write is registered on CLK posedge so the port is stable at the GPR negedge write.
module gpr_wb_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter bit          DROP_R0 = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 hold,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_reg,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 GPRWr,
  output logic [4:0]           W_Reg,
  output logic [31:0]          W_data,
  output logic                 conflict
);

  localparam int unsigned PtrW = $clog2(NREQ);
  typedef logic [PtrW-1:0] ptr_t;

  if (NREQ < 2 || NREQ > 4) begin : gen_nreq_check
    $error("gpr_wb_arbiter: NREQ must be in 2..4");
  end

  logic [4:0]  reg_arr  [NREQ];
  logic [31:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : gen_unpack
    assign reg_arr[i]  = req_reg[5*i +: 5];
    assign data_arr[i] = req_data[32*i +: 32];
  end

  ptr_t            rr_ptr_q, rr_ptr_d;
  ptr_t            gnt_idx;
  logic            gnt_found;
  logic [NREQ-1:0] gnt;
  logic            wr_en;
  logic            multi_valid;

  // Rotating-priority search starting at rr_ptr_q; reset and hold both suppress the grant.
  always_comb begin
    int unsigned cand;
    ptr_t        cand_p;
    gnt       = '0;
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr_q;
    cand      = 0;
    cand_p    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_p = ptr_t'(cand);
      if (!gnt_found && req_valid[cand_p]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_p;
      end
    end
    if (hold || !RSTn) begin
      gnt_found = 1'b0;
    end
    if (gnt_found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  assign req_ready = gnt;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_found) begin
      rr_ptr_d = (gnt_idx == ptr_t'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Writes to r0 still complete the handshake but never reach the register file.
  assign wr_en       = !(DROP_R0 && (reg_arr[gnt_idx] == 5'd0));
  assign multi_valid = ($countones(req_valid) > 1);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      GPRWr    <= 1'b0;
      W_Reg    <= 5'd0;
      W_data   <= 32'd0;
      conflict <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      conflict <= multi_valid && !hold;
      rr_ptr_q <= rr_ptr_d;
      if (gnt_found) begin
        GPRWr  <= wr_en;
        W_Reg  <= reg_arr[gnt_idx];
        W_data <= data_arr[gnt_idx];
      end else begin
        GPRWr  <= 1'b0;
      end
    end
  end

endmodule
